countdown_timer: RTL and testbench



---
 rtl/countdown_timer_if.sv | 25 ++
 rtl/countdown_timer.sv | 85 ++++++++
 tb/tb_countdown_timer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Control and status bundle for countdown_timer: load/enable/abort in,
// remaining count and state flags out.
interface countdown_timer_if #(
    parameter int WIDTH = 13
);
    logic             Load;
    logic [WIDTH-1:0] LoadValue;
    logic             Enable;
    logic             Abort;
    logic [WIDTH-1:0] count;
    logic             Busy;
    logic             Done;
    logic             Expired;

    // Master drives the controls and watches the status; the timer is the slave.
    modport master (
        output Load, LoadValue, Enable, Abort,
        input  count, Busy, Done, Expired
    );

    modport slave (
        input  Load, LoadValue, Enable, Abort,
        output count, Busy, Done, Expired
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with IDLE/RUN/EXPIRED control; counts LoadValue
// Enable ticks down to zero, then pulses Done and holds Expired.
module countdown_timer #(
    parameter int WIDTH = 13
) (
    input logic              Clock,
    input logic              Reset,
    countdown_timer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } TimerState;

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    TimerState        state;
    TimerState        nextState;
    logic [WIDTH-1:0] countReg;
    logic [WIDTH-1:0] nextCount;
    logic             doneReg;
    logic             nextDone;

    // State, count and the Done pulse all clear asynchronously so a reset
    // mid-countdown is visible on the outputs before the next edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            countReg <= '0;
            doneReg  <= 1'b0;
        end else begin
            state    <= nextState;
            countReg <= nextCount;
            doneReg  <= nextDone;
        end
    end

    // Load beats Abort beats Enable; Done is raised only on edges entering EXPIRED.
    always_comb begin
        nextState = state;
        nextCount = countReg;
        nextDone  = 1'b0;
        if (bus.Load) begin
            nextCount = bus.LoadValue;
            if (bus.LoadValue != '0) begin
                nextState = RUN;
            end else begin
                nextState = EXPIRED;
                nextDone  = 1'b1;
            end
        end else if (bus.Abort) begin
            nextState = IDLE;
            nextCount = '0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.Enable) begin
                        if (countReg <= One) begin
                            nextCount = '0;
                            nextState = EXPIRED;
                            nextDone  = 1'b1;
                        end else begin
                            nextCount = countReg - One;
                        end
                    end
                end
                IDLE, EXPIRED: begin
                    nextCount = '0;
                end
                default: begin
                    nextState = IDLE;
                    nextCount = '0;
                end
            endcase
        end
    end

    assign bus.count   = countReg;
    assign bus.Busy    = (state == RUN);
    assign bus.Expired = (state == EXPIRED);
    assign bus.Done    = doneReg;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed and randomized checks of countdown_timer against a
// remaining-ticks reference model.
module tb_countdown_timer;

    localparam int WIDTH = 13;

    logic Clock;
    logic Reset;
    int   compared;
    int   mismatched;

    // Reference model: ticks left, and whether the timer is counting or has run out.
    int mRemain;
    bit mRunning;
    bit mExpired;
    bit mDone;

    countdown_timer_if #(.WIDTH(WIDTH)) bus ();

    countdown_timer #(.WIDTH(WIDTH)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clock = ~Clock;

    task automatic resetModel();
        mRemain  = 0;
        mRunning = 0;
        mExpired = 0;
        mDone    = 0;
    endtask

    task automatic updateModel(input bit load, input int value, input bit enable, input bit abort);
        mDone = 0;
        if (load) begin
            mRemain  = value;
            mRunning = (value != 0);
            mExpired = (value == 0);
            mDone    = (value == 0);
        end else if (abort) begin
            mRemain  = 0;
            mRunning = 0;
            mExpired = 0;
        end else if (mRunning && enable) begin
            mRemain = mRemain - 1;
            if (mRemain == 0) begin
                mRunning = 0;
                mExpired = 1;
                mDone    = 1;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [WIDTH-1:0] expCount;
        expCount = WIDTH'(mRemain);
        compared++;
        assert (bus.count === expCount) else begin
            mismatched++;
            $error("[TB] FAIL %s.count: observed %0d expected %0d", tag, bus.count, expCount);
        end
        compared++;
        assert (bus.Busy === mRunning) else begin
            mismatched++;
            $error("[TB] FAIL %s.Busy: observed %b expected %b", tag, bus.Busy, mRunning);
        end
        compared++;
        assert (bus.Done === mDone) else begin
            mismatched++;
            $error("[TB] FAIL %s.Done: observed %b expected %b", tag, bus.Done, mDone);
        end
        compared++;
        assert (bus.Expired === mExpired) else begin
            mismatched++;
            $error("[TB] FAIL %s.Expired: observed %b expected %b", tag, bus.Expired, mExpired);
        end
    endtask

    task automatic applyStimulus(input bit load, input int value, input bit enable, input bit abort,
                                 input string tag);
        bus.Load      = load;
        bus.LoadValue = WIDTH'(value);
        bus.Enable    = enable;
        bus.Abort     = abort;
        @(posedge Clock);
        updateModel(load, value, enable, abort);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        int cycles;
        bit doneSeen;
        int r;
        int value;

        compared      = 0;
        mismatched    = 0;
        Clock         = 0;
        Reset         = 1;
        bus.Load      = 0;
        bus.LoadValue = '0;
        bus.Enable    = 0;
        bus.Abort     = 0;
        resetModel();
        #12;
        checkOutput("reset");
        @(negedge Clock);
        Reset = 0;

        // Asynchronous reset in the middle of a countdown at 37
        applyStimulus(1, 40, 0, 0, "rst_load");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, "rst_tick");
        compared++;
        assert (bus.count === 13'd37) else begin
            mismatched++;
            $error("[TB] FAIL rst_pre.count: observed %0d expected 37", bus.count);
        end
        #2;
        Reset = 1;
        #1;
        resetModel();
        checkOutput("rst_async");
        @(negedge Clock);
        Reset = 0;
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, "rst_idle");

        // Load 5 with Enable every cycle, then keep ticking past zero
        applyStimulus(1, 5, 1, 0, "l5_load");
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 0, "l5_tick");

        // Load 4 with Enable every third cycle
        applyStimulus(1, 4, 0, 0, "l4_load");
        for (int i = 0; i < 13; i++) applyStimulus(0, 0, (i % 3 == 2), 0, "l4_tick");

        // Load 0 from IDLE
        applyStimulus(0, 0, 0, 1, "l0_abort");
        applyStimulus(1, 0, 1, 0, "l0_load");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, "l0_hold");
        applyStimulus(1, 0, 0, 0, "l0_reload");
        applyStimulus(0, 0, 0, 0, "l0_after");

        // Load and Abort together: Load wins; then Abort alone
        applyStimulus(1, 10, 1, 0, "prio_load");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, "prio_tick");
        applyStimulus(1, 20, 1, 1, "prio_both");
        applyStimulus(0, 0, 1, 1, "prio_abort");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, "prio_idle");

        // Full-scale load, Done must arrive exactly 8191 ticks later
        applyStimulus(1, 8191, 1, 0, "max_load");
        cycles   = 0;
        doneSeen = 0;
        while (!doneSeen && cycles < 9000) begin
            applyStimulus(0, 0, 1, 0, "max_tick");
            cycles++;
            if (bus.Done === 1'b1) doneSeen = 1;
        end
        compared++;
        assert (doneSeen && cycles == 8191) else begin
            mismatched++;
            $error("[TB] FAIL max_latency: observed %0d cycles (done=%b) expected 8191", cycles, doneSeen);
        end
        applyStimulus(1, 2, 1, 0, "rearm_load");
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, "rearm_tick");

        // Randomized traffic, biased towards short intervals
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) value = int'($urandom_range(0, 8191));
            else value = int'($urandom_range(0, 12));
            applyStimulus(r < 2, value, $urandom_range(0, 1) == 1, (r == 2) || (r == 3), "rand");
        end

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
